// File: rtl/uart_cmd_if.sv
// Byte handshake between uart_rx/uart_tx and the command decoder.
// The master modport is the UART side; the decoder takes the slave modport.
interface uart_cmd_if;
    logic       rx_done;
    logic [7:0] data_received;
    logic       parity_error;
    logic       tx_busy;
    logic       start_tx;
    logic [7:0] data_to_tx;

    modport master (
        output rx_done,
        output data_received,
        output parity_error,
        output tx_busy,
        input  start_tx,
        input  data_to_tx
    );

    modport slave (
        input  rx_done,
        input  data_received,
        input  parity_error,
        input  tx_busy,
        output start_tx,
        output data_to_tx
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Decodes on/off/toggle bytes from uart_rx into out_enable, echoes each
// accepted byte through uart_tx, and forces the output off on link silence.
module uart_cmd_decoder #(
    parameter logic [7:0] CMD_ON       = 8'hEE,
    parameter logic [7:0] CMD_OFF      = 8'h55,
    parameter logic [7:0] CMD_TOGGLE   = 8'hC3,
    parameter logic [7:0] ERR_REPLY    = 8'hFF,
    parameter int         WDOG_CYCLES  = 96000000,
    parameter int         ECHO_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    uart_cmd_if.slave  bus,
    output logic       out_enable,
    output logic       cmd_error,
    output logic       wdog_expired,
    output logic [7:0] err_count
);

    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam int TW = $clog2(ECHO_TIMEOUT + 1);
    localparam logic [WW-1:0] WDOG_MAX = WW'(WDOG_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(ECHO_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t        state, state_n;
    logic          rx_done_q;
    logic          start_q, start_n;
    logic [7:0]    data_q, data_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic          oe_n, wexp_n, cerr_n;
    logic [7:0]    err_n;

    logic       accept, valid, reject, drop, tmo;
    logic       is_on, is_off, is_tog;
    logic [7:0] echo_byte;
    logic [1:0] err_inc;
    logic [9:0] err_sum;

    assign bus.start_tx   = start_q;
    assign bus.data_to_tx = data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rx_done_q    <= 1'b0;
            start_q      <= 1'b0;
            data_q       <= 8'h00;
            tcnt         <= '0;
            wcnt         <= '0;
            out_enable   <= 1'b0;
            cmd_error    <= 1'b0;
            wdog_expired <= 1'b0;
            err_count    <= 8'h00;
        end else begin
            state        <= state_n;
            rx_done_q    <= bus.rx_done;
            start_q      <= start_n;
            data_q       <= data_n;
            tcnt         <= tcnt_n;
            wcnt         <= wcnt_n;
            out_enable   <= oe_n;
            cmd_error    <= cerr_n;
            wdog_expired <= wexp_n;
            err_count    <= err_n;
        end
    end

    always_comb begin
        accept    = bus.rx_done & ~rx_done_q;
        is_on     = (bus.data_received == CMD_ON);
        is_off    = (bus.data_received == CMD_OFF);
        is_tog    = (bus.data_received == CMD_TOGGLE);
        valid     = accept & ~bus.parity_error & (is_on | is_off | is_tog);
        reject    = accept & ~valid;
        echo_byte = valid ? bus.data_received : ERR_REPLY;

        state_n = state;
        start_n = start_q;
        data_n  = data_q;
        tcnt_n  = tcnt;
        drop    = 1'b0;
        tmo     = 1'b0;
        cerr_n  = reject;
        oe_n    = out_enable;
        wexp_n  = wdog_expired;
        wcnt_n  = (wcnt == WDOG_MAX) ? wcnt : wcnt + 1'b1;

        if ((wcnt == WDOG_MAX) && out_enable) begin
            oe_n   = 1'b0;
            wexp_n = 1'b1;
        end

        // A valid command overrides a coincident watchdog expiry
        if (valid) begin
            wcnt_n = '0;
            wexp_n = 1'b0;
            unique case (1'b1)
                is_on:   oe_n = 1'b1;
                is_off:  oe_n = 1'b0;
                is_tog:  oe_n = ~out_enable;
            endcase
        end

        unique case (state)
            IDLE: begin
                if (accept) begin
                    data_n  = echo_byte;
                    start_n = 1'b1;
                    tcnt_n  = '0;
                    state_n = REQ;
                end
            end
            REQ: begin
                drop = accept;
                if (bus.tx_busy) begin
                    start_n = 1'b0;
                    state_n = BUSY;
                end else if (tcnt == TMO_MAX) begin
                    start_n = 1'b0;
                    tmo     = 1'b1;
                    state_n = IDLE;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            BUSY: begin
                drop = accept;
                if (!bus.tx_busy) state_n = IDLE;
            end
            default: begin
                start_n = 1'b0;
                state_n = IDLE;
            end
        endcase

        err_inc = {1'b0, reject} + {1'b0, drop} + {1'b0, tmo};
        err_sum = {2'b00, err_count} + {8'h00, err_inc};
        err_n   = (err_sum > 10'd255) ? 8'hFF : err_sum[7:0];
    end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Command decoder for the FPGA_modulo receiver side of the main-board UART link. Sits directly downstream of uart_rx. It consumes each received byte, decodes turn_on / turn_off / toggle into a registered output-enable level, and echoes the accepted byte back through uart_tx so the main board can confirm delivery. A watchdog forces the output off if the link goes silent.

Parameters:
CMD_ON, 8'hEE, turn_on command byte
CMD_OFF, 8'h55, turn_off command byte
CMD_TOGGLE, 8'hC3, toggle command byte
ERR_REPLY, 8'hFF, byte echoed for a parity error or an unknown command
WDOG_CYCLES, 96000000, link-silence cycles before forced off (4 s at 24 MHz)
ECHO_TIMEOUT, 16, cycles to wait for tx_busy to rise after start_tx

Ports:
clk  in  1  system clock (24 MHz HFOSC)
reset  in  1  asynchronous, active-high reset
rx_done  in  1  byte-valid strobe from uart_rx; may be held high for more than one cycle
data_received  in  8  received byte; valid while rx_done is high
parity_error  in  1  qualifies the current byte; valid with rx_done
tx_busy  in  1  uart_tx busy level
start_tx  out  1  uart_tx start request (level)
data_to_tx  out  8  echo byte; stable while start_tx or tx_busy is high
out_enable  out  1  decoded enable level, 1 = on
cmd_error  out  1  one-cycle pulse per rejected byte
wdog_expired  out  1  sticky flag; set when the watchdog forces off
err_count  out  8  saturating count of rejected and dropped bytes

Behaviour:
- Reset, asynchronous: start_tx=0, data_to_tx=0, out_enable=0, cmd_error=0, wdog_expired=0, err_count=0, FSM=IDLE, watchdog counter=0, rx_done_q=0. Reset during an echo drops start_tx immediately.
- Byte accept:
  - Condition is rx_done=1 and rx_done_q=0 (internal rising-edge detect), so a held strobe counts once.
  - Decode happens on that edge; outputs are visible one cycle later.
- Decode:
  - parity_error=1: reject.
  - CMD_ON: out_enable<=1.
  - CMD_OFF: out_enable<=0.
  - CMD_TOGGLE: out_enable<=~out_enable.
  - Any other byte: reject.
- Reject: out_enable unchanged; cmd_error pulses 1 cycle; err_count+1, saturating at 255; echo byte = ERR_REPLY.
- Valid command: echo byte = the received byte; watchdog counter <= 0; wdog_expired <= 0.
- Echo FSM:
  - IDLE: on an accepted byte, data_to_tx<=echo byte, start_tx<=1, go to REQ and clear the timeout counter.
  - REQ: when tx_busy=1, start_tx<=0 and go to BUSY. If tx_busy stays low for ECHO_TIMEOUT cycles, start_tx<=0, err_count+1, go to IDLE.
  - BUSY: when tx_busy=0, go to IDLE.
  - start_tx is never high for more than ECHO_TIMEOUT cycles, so uart_tx never retransmits.
- Byte accepted while in REQ or BUSY:
  - Decode and out_enable update still apply.
  - The echo is dropped; err_count+1; data_to_tx is not disturbed.
  - cmd_error pulses only if the byte itself was rejected.
- Watchdog:
  - Counter increments every cycle and saturates at WDOG_CYCLES-1.
  - On reaching WDOG_CYCLES-1 with out_enable=1: out_enable<=0 and wdog_expired<=1.
  - While out_enable=0 the counter still runs, but nothing is forced.
- Simultaneous events:
  - A valid command in the same cycle as watchdog expiry: the command wins, the counter clears, and wdog_expired is not set.
  - Rejected bytes do not clear the watchdog.
- err_count saturates at 8'hFF and never wraps.

Test Plan:
- Reset, then rx_done pulse with 8'hEE, parity 0 -> out_enable=1 next cycle; start_tx=1 with data_to_tx=8'hEE; start_tx drops the cycle after tx_busy rises; FSM returns to IDLE when tx_busy falls.
- 8'hC3 twice with full echo handshakes -> out_enable goes 1 then 0; two echoes of 8'hC3.
- Byte 8'h12, then 8'hEE with parity_error=1 -> out_enable unchanged; two cmd_error pulses; err_count=2; both echoes are 8'hFF.
- 8'hEE, then idle with WDOG_CYCLES=100 -> out_enable=0 and wdog_expired=1 exactly 100 cycles after the accept; a later 8'h55 clears wdog_expired.
- rx_done held high 10 cycles with 8'h55 -> exactly one accept and one echo.
- rx_done 8'h55 while in BUSY -> out_enable=0; no new start_tx; err_count+1.
- tx_busy tied low -> start_tx high for exactly ECHO_TIMEOUT=16 cycles, then 0; err_count=1.
- Reset asserted during REQ -> start_tx=0 and all outputs 0 asynchronously.
